// File: rtl/regfile_sb.sv
// Register file with two async read ports, ALU and late-writeback write ports,
// write-through bypass, zero register, one I/O register and a pending-write scoreboard.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IO_REG = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              lwe,
  input  logic [ADDR_W-1:0] lwaddr,
  input  logic [DATA_W-1:0] lwdata,
  input  logic              claim,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic              ready,
  output logic              state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] IO_A   = ADDR_W'(IO_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep;
  logic [DEPTH-1:0]  busy;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run;
  logic              we_ok;
  logic              lwe_ok;
  logic              claim_ok;

  assign run      = (state == ST_RUN);
  assign we_ok    = run && we && (waddr != '0);
  // The ALU port wins an address collision, so the late write is dropped.
  assign lwe_ok   = run && lwe && (lwaddr != '0) && !(we && (waddr == lwaddr));
  assign claim_ok = run && claim && (claim_addr != '0) && (claim_addr != IO_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_CLEAR;
      sweep  <= ADDR_W'(1);
      io_out <= '0;
    end else if (!run) begin
      sweep <= sweep + ADDR_W'(1);
      if (sweep == LAST_A) state <= ST_RUN;
    end else if (we_ok && (waddr == IO_A)) begin
      io_out <= wdata;
    end else if (lwe_ok && (lwaddr == IO_A)) begin
      io_out <= lwdata;
    end
  end

  // Storage has no reset; the sweep zeroes it before ready rises.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[sweep] <= '0;
    end else begin
      if (we_ok && (waddr != IO_A)) mem[waddr] <= wdata;
      if (lwe_ok && (lwaddr != IO_A)) mem[lwaddr] <= lwdata;
    end
  end

  // A claim issued alongside an lwe to the same register is the newer producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (run) begin
      if (lwe) busy[lwaddr] <= 1'b0;
      if (claim_ok) busy[claim_addr] <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    if (!run || (a == '0))        return '0;
    if (a == IO_A)                return io_in;
    if (we && (waddr == a))       return wdata;
    if (lwe && (lwaddr == a))     return lwdata;
    return mem[a];
  endfunction

  function automatic logic busy_port(input logic [ADDR_W-1:0] a);
    if (!run || (a == '0) || (a == IO_A)) return 1'b0;
    return busy[a] && !(lwe && (lwaddr == a));
  endfunction

  assign rdata1    = read_port(raddr1);
  assign rdata2    = read_port(raddr2);
  assign rbusy1    = busy_port(raddr1);
  assign rbusy2    = busy_port(raddr2);
  assign ready     = run;
  assign state_dbg = state;

endmodule
